// File: rtl/digdug_io_pkg.sv
// Shared constants, CTRL field layout, FSM state types and the NMI reload
// helper for the DigDug 06XX I/O controller.
package digdug_io_pkg;

  localparam int unsigned AD_W   = 16;
  localparam int unsigned D_W    = 8;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = 17;

  localparam logic [7:0] DATA_PAGE = 8'h70;
  localparam logic [7:0] CTRL_PAGE = 8'h71;

  localparam int unsigned DEF_NMI_UNIT  = 9600;
  localparam int unsigned DEF_NMI_WIDTH = 64;

  localparam int unsigned CTRL_SEL_LSB  = 0;
  localparam int unsigned CTRL_DIR_BIT  = 4;
  localparam int unsigned CTRL_CODE_LSB = 5;

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_e;

  typedef enum logic [1:0] {
    NMI_IDLE,
    NMI_COUNT,
    NMI_PULSE
  } nmi_state_e;

  // Down-counter reload so that one full period is exactly code*unit cycles.
  function automatic logic [CNT_W-1:0] nmi_load(input logic [CODE_W-1:0] code,
                                                input int unsigned unit);
    int unsigned prod;
    prod = 32'(code) * unit;
    return CNT_W'(prod - 32'd1);
  endfunction

endpackage

// File: rtl/digdug_io06xx_if.sv
// Time-multiplexed device bus between the CPU arbiter (master) and a device slave.
interface digdug_io06xx_if;
  logic                            DEV_CE;
  logic [digdug_io_pkg::AD_W-1:0]  DEV_AD;
  logic                            DEV_RD;
  logic                            DEV_WR;
  logic [digdug_io_pkg::D_W-1:0]   DEV_DI;
  logic                            DEV_DV;
  logic [digdug_io_pkg::D_W-1:0]   DEV_DO;

  modport master (
    output DEV_CE, DEV_AD, DEV_RD, DEV_WR, DEV_DI,
    input  DEV_DV, DEV_DO
  );

  modport slave (
    input  DEV_CE, DEV_AD, DEV_RD, DEV_WR, DEV_DI,
    output DEV_DV, DEV_DO
  );
endinterface

// File: rtl/digdug_nmi_timer.sv
// Periodic NMI generator: period code*NMI_UNIT cycles, pulse NMI_WIDTH cycles,
// restarted by every CTRL write.
module digdug_nmi_timer
  import digdug_io_pkg::*;
#(
  parameter int unsigned NMI_UNIT  = DEF_NMI_UNIT,
  parameter int unsigned NMI_WIDTH = DEF_NMI_WIDTH
) (
  input  logic              CLK48M,
  input  logic              RESET_N,
  input  logic [CODE_W-1:0] code,
  input  logic              restart,
  output logic              NMI_O
);

  localparam int unsigned WCNT_W = (NMI_WIDTH > 1) ? $clog2(NMI_WIDTH) : 1;

  nmi_state_e        state;
  logic [CODE_W-1:0] code_q;
  logic [CNT_W-1:0]  cnt;
  logic [WCNT_W-1:0] wcnt;

  // Restart has priority over a coinciding expiry, so no pulse escapes.
  always_ff @(posedge CLK48M) begin
    if (!RESET_N) begin
      state  <= NMI_IDLE;
      code_q <= '0;
      cnt    <= '0;
      wcnt   <= '0;
      NMI_O  <= 1'b0;
    end else if (restart) begin
      code_q <= code;
      wcnt   <= '0;
      NMI_O  <= 1'b0;
      if (code == '0) begin
        state <= NMI_IDLE;
        cnt   <= '0;
      end else begin
        state <= NMI_COUNT;
        cnt   <= nmi_load(code, NMI_UNIT);
      end
    end else begin
      case (state)
        NMI_COUNT: begin
          if (cnt == '0) begin
            cnt   <= nmi_load(code_q, NMI_UNIT);
            wcnt  <= WCNT_W'(NMI_WIDTH - 1);
            NMI_O <= 1'b1;
            state <= NMI_PULSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        NMI_PULSE: begin
          // The period counter keeps running underneath the pulse.
          if (cnt == '0) cnt <= nmi_load(code_q, NMI_UNIT);
          else           cnt <= cnt - CNT_W'(1);
          if (wcnt == '0) begin
            NMI_O <= 1'b0;
            state <= NMI_COUNT;
          end else begin
            wcnt <= wcnt - WCNT_W'(1);
          end
        end
        default: begin
          NMI_O <= 1'b0;
          state <= NMI_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/digdug_io06xx.sv
// Namco 06XX device-bus slave: decodes DATA/CTRL pages, forwards data cycles
// to the selected custom I/O chip and drives the CPU0 NMI.
module digdug_io06xx
  import digdug_io_pkg::*;
#(
  parameter int unsigned NMI_UNIT  = DEF_NMI_UNIT,
  parameter int unsigned NMI_WIDTH = DEF_NMI_WIDTH
) (
  input  logic             CLK48M,
  input  logic             RESET_N,
  digdug_io06xx_if.slave   dev,
  output logic [SEL_W-1:0] IO_SEL,
  output logic             IO_RD,
  output logic             IO_WR,
  output logic [D_W-1:0]   IO_DO,
  input  logic [D_W-1:0]   IO_DI,
  output logic             NMI_O
);

  bus_state_e     bus_state;
  logic [D_W-1:0] ctrl_q;
  logic           dev_dv_q;
  logic [D_W-1:0] dev_do_q;

  logic [7:0] page;
  logic       data_hit;
  logic       ctrl_hit;
  logic       is_wr;
  logic       take;
  logic       ctrl_wr;
  logic       unused_ad;

  // Only the page byte selects this block; RD together with WR counts as a write.
  assign page      = dev.DEV_AD[AD_W-1 -: 8];
  assign unused_ad = ^dev.DEV_AD[7:0];
  assign data_hit  = (page == DATA_PAGE);
  assign ctrl_hit  = (page == CTRL_PAGE);
  assign is_wr     = dev.DEV_WR;
  assign take      = dev.DEV_CE & (data_hit | ctrl_hit) & (dev.DEV_RD | dev.DEV_WR);
  assign ctrl_wr   = take & ctrl_hit & is_wr;

  assign IO_SEL     = ctrl_q[CTRL_SEL_LSB +: SEL_W];
  assign dev.DEV_DV = dev_dv_q;
  assign dev.DEV_DO = dev_do_q;

  // Bus FSM: every DEV_CE closes the current response and decodes a new cycle.
  always_ff @(posedge CLK48M) begin
    if (!RESET_N) begin
      bus_state <= BUS_IDLE;
      ctrl_q    <= '0;
      dev_dv_q  <= 1'b0;
      dev_do_q  <= '0;
      IO_RD     <= 1'b0;
      IO_WR     <= 1'b0;
      IO_DO     <= '0;
    end else begin
      IO_RD <= 1'b0;
      IO_WR <= 1'b0;
      if (dev.DEV_CE) begin
        dev_dv_q  <= 1'b0;
        bus_state <= BUS_IDLE;
        if (take) begin
          bus_state <= BUS_RESP;
          if (ctrl_hit) begin
            if (is_wr) begin
              ctrl_q <= dev.DEV_DI;
            end else begin
              dev_dv_q <= 1'b1;
              dev_do_q <= ctrl_q;
            end
          end else if (is_wr) begin
            if (!ctrl_q[CTRL_DIR_BIT]) begin
              IO_WR <= 1'b1;
              IO_DO <= dev.DEV_DI;
            end
          end else begin
            dev_dv_q <= 1'b1;
            if (ctrl_q[CTRL_DIR_BIT]) begin
              IO_RD    <= 1'b1;
              dev_do_q <= IO_DI;
            end else begin
              dev_do_q <= 8'hFF;
            end
          end
        end
      end else if (bus_state == BUS_RESP && IO_RD) begin
        // Final capture of chip data during the strobe cycle.
        dev_do_q <= IO_DI;
      end
    end
  end

  digdug_nmi_timer #(
    .NMI_UNIT  (NMI_UNIT),
    .NMI_WIDTH (NMI_WIDTH)
  ) u_nmi (
    .CLK48M  (CLK48M),
    .RESET_N (RESET_N),
    .code    (dev.DEV_DI[CTRL_CODE_LSB +: CODE_W]),
    .restart (ctrl_wr),
    .NMI_O   (NMI_O)
  );

endmodule

// File: tb/tb_digdug_io06xx.sv
// Scoreboard bench for digdug_io06xx with a cycle-indexed NMI reference model.
module tb_digdug_io06xx;
  import digdug_io_pkg::*;

  // Scaled NMI unit keeps the run short; width stays at its real value.
  localparam int unsigned U = 200;
  localparam int unsigned W = 64;

  logic       CLK48M = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] IO_SEL;
  logic       IO_RD, IO_WR, NMI_O;
  logic [7:0] IO_DO;
  logic [7:0] IO_DI = 8'hFF;

  always #5 CLK48M = ~CLK48M;

  digdug_io06xx_if dev();

  digdug_io06xx #(.NMI_UNIT(U), .NMI_WIDTH(W)) dut (
    .CLK48M (CLK48M),
    .RESET_N(RESET_N),
    .dev    (dev),
    .IO_SEL (IO_SEL),
    .IO_RD  (IO_RD),
    .IO_WR  (IO_WR),
    .IO_DO  (IO_DO),
    .IO_DI  (IO_DI),
    .NMI_O  (NMI_O)
  );

  typedef struct { logic dv; logic [7:0] d; } rsp_t;
  typedef struct { logic rd; logic [3:0] sel; logic [7:0] d; } io_t;

  rsp_t rsp_q[$];
  io_t  io_q[$];
  rsp_t cur;
  io_t  ie;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  int unsigned last_e0 = 0;

  // Reference state: CTRL contents and time/code of the last timer restart.
  logic [7:0]  m_ctrl = 8'h00;
  int unsigned m_code = 0;
  int unsigned m_t0   = 0;

  logic ce_s = 1'b0, rst_s = 1'b0, hold_on = 1'b0;
  logic mon_exp, prev_exp = 1'b0, prev_nmi = 1'b0;

  always @(posedge CLK48M) begin
    cyc   <= cyc + 1;
    ce_s  <= dev.DEV_CE;
    rst_s <= RESET_N;
  end

  // Expected NMI level after edge k: high for W cycles starting at every multiple of the period.
  function automatic logic nmi_exp(input int unsigned k);
    int unsigned p, d;
    p = m_code * U;
    if (m_code == 0 || k < m_t0) return 1'b0;
    d = k - m_t0;
    if (d < p) return 1'b0;
    return ((d % p) < W);
  endfunction

  task automatic check_rsp(input string name);
    tests++;
    if (dev.DEV_DV !== cur.dv || (cur.dv && dev.DEV_DO !== cur.d)) begin
      fails++;
      $display("FAIL %s @%0d: got dv=%0b do=%02h, want dv=%0b do=%02h",
               name, cyc, dev.DEV_DV, dev.DEV_DO, cur.dv, cur.d);
    end
  endtask

  // Monitor: pops expected responses/strobes as the DUT presents them.
  always @(negedge CLK48M) begin
    if (!rst_s) begin
      hold_on = 1'b0;
      tests++;
      if ({dev.DEV_DV, dev.DEV_DO, IO_SEL, IO_RD, IO_WR, IO_DO, NMI_O} !== 24'h0) begin
        fails++;
        $display("FAIL reset_vals @%0d: got dv=%0b do=%02h sel=%h rd=%0b wr=%0b io_do=%02h nmi=%0b, want all 0",
                 cyc, dev.DEV_DV, dev.DEV_DO, IO_SEL, IO_RD, IO_WR, IO_DO, NMI_O);
      end
    end else begin
      if (ce_s) begin
        if (rsp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rsp_unexpected @%0d: got a bus sample, want none queued", cyc);
        end else begin
          cur = rsp_q.pop_front();
          hold_on = 1'b1;
          check_rsp("rsp");
        end
      end else if (hold_on) begin
        check_rsp("rsp_hold");
      end
      if (IO_RD || IO_WR) begin
        tests++;
        if (io_q.size() == 0) begin
          fails++;
          $display("FAIL strobe_unexpected @%0d: got rd=%0b wr=%0b sel=%h, want no strobe",
                   cyc, IO_RD, IO_WR, IO_SEL);
        end else begin
          ie = io_q.pop_front();
          if (IO_RD !== ie.rd || IO_WR !== !ie.rd || IO_SEL !== ie.sel ||
              (!ie.rd && IO_DO !== ie.d)) begin
            fails++;
            $display("FAIL strobe @%0d: got rd=%0b wr=%0b sel=%h do=%02h, want rd=%0b wr=%0b sel=%h do=%02h",
                     cyc, IO_RD, IO_WR, IO_SEL, IO_DO, ie.rd, !ie.rd, ie.sel, ie.d);
          end
        end
      end
    end
    mon_exp = nmi_exp(cyc);
    if (mon_exp !== prev_exp || NMI_O !== prev_nmi) begin
      tests++;
      if (NMI_O !== mon_exp) begin
        fails++;
        $display("FAIL nmi_level @%0d: got %0b, want %0b", cyc, NMI_O, mon_exp);
      end
    end
    prev_exp = mon_exp;
    prev_nmi = NMI_O;
  end

  // One bus cycle: DEV_CE for one clock, then gap idle clocks.
  task automatic bus_op(input logic [15:0] ad, input logic rd, input logic wr,
                        input logic [7:0] di, input logic [7:0] iodi, input int gap);
    rsp_t r;
    io_t  e;
    logic [7:0] pg, drv;
    logic ctrl_w;
    int unsigned e0;
    @(negedge CLK48M);
    pg  = ad[15:8];
    drv = (m_ctrl[3:0] == 4'h0) ? 8'hFF : iodi;
    dev.DEV_CE = 1'b1; dev.DEV_AD = ad; dev.DEV_RD = rd; dev.DEV_WR = wr; dev.DEV_DI = di;
    IO_DI = drv;
    r.dv = 1'b0; r.d = 8'h00; ctrl_w = 1'b0;
    if ((pg == 8'h70 || pg == 8'h71) && (rd || wr)) begin
      if (pg == 8'h71) begin
        if (wr) ctrl_w = 1'b1;
        else begin r.dv = 1'b1; r.d = m_ctrl; end
      end else if (wr) begin
        if (!m_ctrl[4]) begin e.rd = 1'b0; e.sel = m_ctrl[3:0]; e.d = di; io_q.push_back(e); end
      end else begin
        r.dv = 1'b1;
        if (m_ctrl[4]) begin
          r.d = drv; e.rd = 1'b1; e.sel = m_ctrl[3:0]; e.d = 8'h00; io_q.push_back(e);
        end else begin
          r.d = 8'hFF;
        end
      end
    end
    rsp_q.push_back(r);
    e0 = cyc + 1;
    last_e0 = e0;
    @(posedge CLK48M);
    if (ctrl_w) begin m_ctrl = di; m_code = int'(di[7:5]); m_t0 = e0; end
    @(negedge CLK48M);
    dev.DEV_CE = 1'b0; dev.DEV_RD = 1'b0; dev.DEV_WR = 1'b0;
    repeat (gap) @(negedge CLK48M);
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK48M);
    RESET_N = 1'b0;
    @(posedge CLK48M);
    m_ctrl = 8'h00; m_code = 0; m_t0 = 0;
    repeat (n) @(negedge CLK48M);
    RESET_N = 1'b1;
  endtask

  task automatic wait_rise(input string name);
    int n;
    n = 0;
    while (NMI_O !== 1'b1 && n < 4000) begin
      @(negedge CLK48M);
      n++;
    end
    if (n >= 4000) begin
      tests++; fails++;
      $display("FAIL %s: got no NMI rise within 4000 cycles, want a rise", name);
    end
  endtask

  initial begin
    dev.DEV_CE = 1'b0; dev.DEV_AD = 16'h0000; dev.DEV_RD = 1'b0;
    dev.DEV_WR = 1'b0; dev.DEV_DI = 8'h00;
    repeat (3) @(negedge CLK48M);
    RESET_N = 1'b1;
    repeat (2000) @(negedge CLK48M);
    tests++;
    if (NMI_O !== 1'b0 || dev.DEV_DV !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got nmi=%0b dv=%0b, want 0 0", NMI_O, dev.DEV_DV);
    end

    // Code 1 period, five periods observed.
    bus_op(16'h7100, 1'b0, 1'b1, 8'h20, 8'h00, 2);
    repeat (5 * U + 100) @(negedge CLK48M);

    // Chip write to select 0001, period code 7.
    bus_op(16'h7100, 1'b0, 1'b1, 8'hE1, 8'h00, 2);
    bus_op(16'h7000, 1'b0, 1'b1, 8'h5A, 8'h00, 2);
    repeat (7 * U + 200) @(negedge CLK48M);

    // Chip read from select 0010.
    bus_op(16'h7100, 1'b0, 1'b1, 8'h12, 8'h00, 2);
    bus_op(16'h7000, 1'b1, 1'b0, 8'h00, 8'hC3, 6);
    bus_op(16'h7100, 1'b1, 1'b0, 8'h00, 8'h00, 2);

    // Direction mismatch, then an address miss.
    bus_op(16'h7100, 1'b0, 1'b1, 8'h01, 8'h00, 2);
    bus_op(16'h7000, 1'b1, 1'b0, 8'h00, 8'hC3, 2);
    bus_op(16'h6800, 1'b1, 1'b0, 8'h00, 8'hC3, 2);
    bus_op(16'h7000, 1'b1, 1'b1, 8'h77, 8'h00, 2);

    // Code 0 written during the 30th pulse cycle.
    bus_op(16'h7100, 1'b0, 1'b1, 8'h20, 8'h00, 2);
    wait_rise("nmi_rise_a");
    repeat (27) @(negedge CLK48M);
    bus_op(16'h7100, 1'b0, 1'b1, 8'h00, 8'h00, 300);

    // CTRL write landing exactly on the counter expiry.
    bus_op(16'h7100, 1'b0, 1'b1, 8'h20, 8'h00, 2);
    while (cyc + 2 < last_e0 + U) @(negedge CLK48M);
    bus_op(16'h7100, 1'b0, 1'b1, 8'h40, 8'h00, 4 * U + 100);

    for (int i = 0; i < 150; i++) begin
      logic [15:0] ad;
      int k;
      k = $urandom_range(0, 9);
      ad = 16'($urandom);
      if (k < 4)      ad[15:8] = 8'h70;
      else if (k < 7) ad[15:8] = 8'h71;
      else if (k < 8) ad[15:8] = 8'h68;
      bus_op(ad, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 7) == 0) ? $urandom_range(100, 600) : $urandom_range(2, 6));
    end

    // Reset during an NMI pulse and a held read response.
    bus_op(16'h7100, 1'b0, 1'b1, 8'h32, 8'h00, 2);
    wait_rise("nmi_rise_b");
    bus_op(16'h7000, 1'b1, 1'b0, 8'h00, 8'hA5, 2);
    do_reset(2);
    repeat (20) @(negedge CLK48M);

    tests++;
    if (rsp_q.size() != 0 || io_q.size() != 0) begin
      fails++;
      $display("FAIL queues_drained: got rsp=%0d io=%0d left, want 0 0", rsp_q.size(), io_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/digdug_io06xx.md
# digdug_io06xx

Device-bus slave for the DigDug CPU complex, modelling the Namco 06XX I/O controller. Sits directly downstream of the three-CPU bus arbiter: decodes the time-multiplexed device bus at 0x7000–0x71FF, forwards data cycles to the selected custom I/O chip, and generates the periodic NMI that feeds the arbiter's CPU0 NMI input.

## Interface
Parameters:
- NMI_UNIT, 9600: MCLK cycles per NMI period step (200 µs at 48 MHz).
- NMI_WIDTH, 64: NMI_O high time in MCLK cycles (4 CPU clocks).

Ports:
- CLK48M  in  1  master clock, 48 MHz; only clock.
- RESET_N  in  1  reset; synchronous to CLK48M, active-low.
- DEV_CE  in  1  one-cycle strobe, aligned to the DEV_CL rising edge; marks a bus sample point.
- DEV_AD  in  16  device-bus address.
- DEV_RD  in  1  read request.
- DEV_WR  in  1  write request.
- DEV_DI  in  8  write data from the bus.
- DEV_DV  out  1  read data valid, this block hit.
- DEV_DO  out  8  read data.
- IO_SEL  out  4  one-hot chip select (CTRL[3:0]).
- IO_RD  out  1  one-cycle read strobe to the selected chip.
- IO_WR  out  1  one-cycle write strobe to the selected chip.
- IO_DO  out  8  write data to the chip.
- IO_DI  in  8  chip read data; valid in the IO_RD cycle.
- NMI_O  out  1  NMI request level to CPU0.

## Operation
- Decode on DEV_CE only. DATA hit: DEV_AD[15:8]==0x70. CTRL hit: DEV_AD[15:8]==0x71. Other addresses are ignored and DEV_DV stays 0.
- CTRL register, 8 bits. [3:0] chip select, [4] direction (1 = read), [7:5] NMI period code.
- CTRL write: the register loads DEV_DI. The NMI timer restarts.
- CTRL read: DEV_DO = CTRL.
- DATA write with CTRL[4]=0: IO_WR pulses, IO_DO = DEV_DI.
- DATA write with CTRL[4]=1: no strobe is issued.
- DATA read with CTRL[4]=1: IO_RD pulses, DEV_DO = IO_DI captured in that cycle.
- DATA read with CTRL[4]=0: DEV_DO = 0xFF, no strobe.
- When CTRL[3:0]==0, strobes still issue. A DATA read then returns 0xFF because IO_DI is pulled up by the parent.
- Bus FSM has two states:
  - IDLE: on DEV_CE with a hit and RD or WR asserted, capture the cycle and go to RESP.
  - RESP: DEV_DV=1 for a read. Return to IDLE on the next DEV_CE. That same DEV_CE is also decoded as a new cycle.
- RD and WR asserted together: treated as a write.
- NMI FSM has three states:
  - IDLE: code==0, NMI_O=0.
  - COUNT: down-counter loaded with code*NMI_UNIT-1. At 0 go to PULSE and reload.
  - PULSE: NMI_O=1 for NMI_WIDTH cycles, counter keeps running, then back to COUNT.
  - The period is exactly code*NMI_UNIT cycles.
- Counter is 17 bits unsigned; maximum load is 67199.

## Timing
- Reset values: CTRL=0x00, DEV_DV=0, DEV_DO=0x00, IO_SEL=0, IO_RD=0, IO_WR=0, IO_DO=0x00, NMI_O=0. Both FSMs start in IDLE.
- Read latency: DEV_DV and DEV_DO are registered, valid 1 MCLK after the sampling DEV_CE. They hold until 1 MCLK after the next DEV_CE, which keeps them inside the 4-MCLK arbiter slot.
- IO_RD and IO_WR go high 1 MCLK after DEV_CE, for exactly 1 cycle.
- IO_SEL follows CTRL combinationally from the register.
- After a CTRL write with code n≠0, the first NMI_O rise comes n*NMI_UNIT MCLK after the write's DEV_CE.
- A CTRL write with code 0 drops NMI_O on the next MCLK, including mid-pulse.
- CTRL write coinciding with counter expiry: the write wins; no pulse is issued.
- Reset mid-pulse or mid-response: all outputs return to reset values on the next edge.

## Structure
- Package digdug_io_pkg:
  - DATA_PAGE = 8'h70, CTRL_PAGE = 8'h71.
  - NMI_UNIT and NMI_WIDTH defaults.
  - CTRL bit-field positions.
  - FSM state typedefs.
- Sub-module digdug_nmi_timer holds the period code input, the restart strobe, the counter and the PULSE logic, and outputs NMI_O. The bus decode and CTRL register stay in the top module.

## Test plan
- Reset release: after reset, every output is 0 and DEV_DO=0x00. No NMI appears within 100k cycles.
- NMI period: write 0x7100 ← 0x20 (code 1, select none) → NMI_O rises 9600 cycles after the write. Each pulse is high for 64 cycles, with period 9600; measure 5 periods.
- Chip write and period change: write 0x7100 ← 0xE1, then 0x7000 ← 0x5A.
  - One IO_WR pulse with IO_SEL=0001 and IO_DO=0x5A.
  - NMI period becomes 67200 cycles.
- Chip read: write 0x7100 ← 0x12, bench drives IO_DI=0xC3, then read 0x7000.
  - One IO_RD pulse with IO_SEL=0010.
  - DEV_DV=1 and DEV_DO=0xC3 one cycle after DEV_CE, held until the next DEV_CE.
- Direction mismatch and miss: with CTRL=0x01, read 0x7000 → 0xFF and no IO_RD. Read of 0x6800 → DEV_DV stays 0.
- Boundary cases:
  - Write 0x7100 ← 0x00 during the 30th cycle of a pulse → NMI_O=0 next cycle.
  - Write 0x7100 ← 0x40 on the exact expiry cycle → no pulse; next rise 19200 cycles later.
  - Assert RESET_N=0 mid-read → DEV_DV=0 on the next edge.
